// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle of an async FIFO: pop request, storage port, pointers and status.
// Latency: none, wires only.
// Backpressure: rempty/rvalid tell the consumer when rinc will be honoured.
interface fifo_rd_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);

  // consumer / write domain / storage side
  logic              rinc;
  logic [ADDR_W:0]   wptr_gray;
  logic [DATA_W-1:0] mem_rdata;

  // controller side
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W:0]   rptr_gray;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rempty;
  logic              raempty;
  logic [ADDR_W:0]   rcount;
  logic              runderflow;

  // environment: consumer, write-domain pointer and storage read port
  modport master (
    output rinc, wptr_gray, mem_rdata,
    input  raddr, rptr_gray, rdata, rvalid, rempty, raempty, rcount, runderflow
  );

  // read controller
  modport slave (
    input  rinc, wptr_gray, mem_rdata,
    output raddr, rptr_gray, rdata, rvalid, rempty, raempty, rcount, runderflow
  );

endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of an async FIFO: syncs the Gray write pointer, pops storage, flags.
// Latency: data 1 cycle after accepted rinc (or after rempty falls with FIFO_RD_FWFT_EN); flags SYNC_STAGES+1 after a write.
// Backpressure: pops only when data is held; a refused rinc sets the sticky runderflow flag.
// Optional: define FIFO_RD_FWFT_EN for first-word-fall-through output staging.
module fifo_rd_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,   // 2..4
  parameter int AEMPTY_TH   = 2
) (
  input  logic          clk,
  input  logic          rst,       // asynchronous, active-low
  fifo_rd_ctrl_if.slave rd
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;
  // A threshold beyond the depth would make raempty permanently set anyway.
  localparam int AE_CLAMP = (AEMPTY_TH > DEPTH) ? DEPTH : AEMPTY_TH;
  localparam logic [PW-1:0] AE_TH = PW'(AE_CLAMP);

  // Gray helpers for the cross-domain pointers.
  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0]     sync_q [SYNC_STAGES];
  logic [PW-1:0]     wq_gray;
  logic [PW-1:0]     wq_bin;

  logic [PW-1:0]     rbin_q,       rbin_d;
  logic [PW-1:0]     rptr_gray_q,  rptr_gray_d;
  logic [PW-1:0]     rcount_q,     rcount_d;
  logic [DATA_W-1:0] rdata_q,      rdata_d;
  logic              rvalid_q,     rvalid_d;
  logic              rempty_q,     rempty_d;
  logic              raempty_q,    raempty_d;
  logic              runderflow_q, runderflow_d;

  logic              pop_acc;      // storage entry consumed on this edge
  logic              uf_evt;       // rinc that could not be honoured

  // Write-pointer synchronizer; only the last stage is ever looked at.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rd.wptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wq_gray = sync_q[SYNC_STAGES-1];
  assign wq_bin  = gray2bin(wq_gray);

  // Pop decision and output-stage next state; the two modes differ only here.
  always_comb begin
    pop_acc  = 1'b0;
    uf_evt   = 1'b0;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
`ifdef FIFO_RD_FWFT_EN
    // Refill the single output register whenever it is vacant or being
    // consumed this cycle, as long as storage still holds an entry.
    pop_acc = !rempty_q && (!rvalid_q || rd.rinc);
    uf_evt  = rd.rinc && !rvalid_q;
    if (pop_acc) begin
      rdata_d  = rd.mem_rdata;
      rvalid_d = 1'b1;
    end else if (rd.rinc && rvalid_q) begin
      rvalid_d = 1'b0;
    end
`else
    // rvalid is a one-cycle strobe that follows each accepted rinc.
    pop_acc  = rd.rinc && !rempty_q;
    uf_evt   = rd.rinc && !pop_acc;
    rvalid_d = pop_acc;
    if (pop_acc) begin
      rdata_d = rd.mem_rdata;
    end
`endif
  end

  // Pointer and flag next state, all derived from the post-pop pointer so
  // empty/count reflect this edge's pop with no extra lag.
  always_comb begin
    rbin_d       = rbin_q + PW'(pop_acc);
    rptr_gray_d  = bin2gray(rbin_d);
    rempty_d     = (rptr_gray_d == wq_gray);
    rcount_d     = wq_bin - rbin_d;
    raempty_d    = (rcount_d <= AE_TH);
    runderflow_d = runderflow_q | uf_evt;
  end

  // Read-domain state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rbin_q       <= '0;
      rptr_gray_q  <= '0;
      rcount_q     <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_gray_q  <= rptr_gray_d;
      rcount_q     <= rcount_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      rempty_q     <= rempty_d;
      raempty_q    <= raempty_d;
      runderflow_q <= runderflow_d;
    end
  end

  // Storage address comes straight off the pointer register, so the
  // combinational mem_rdata already shows the head entry.
  assign rd.raddr      = rbin_q[ADDR_W-1:0];
  assign rd.rptr_gray  = rptr_gray_q;
  assign rd.rdata      = rdata_q;
  assign rd.rvalid     = rvalid_q;
  assign rd.rempty     = rempty_q;
  assign rd.raempty    = raempty_q;
  assign rd.rcount     = rcount_q;
  assign rd.runderflow = runderflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: models the write side and storage, scoreboards popped data.
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns after posedge.
// Backpressure: only pops entries the bench knows are already visible to the reader.
module tb_fifo_rd_ctrl;

  localparam int ADDR_W      = 4;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int AEMPTY_TH   = 2;
  localparam int PW          = ADDR_W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fifo_rd_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rif ();

  fifo_rd_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .AEMPTY_TH(AEMPTY_TH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd (rif)
  );

  logic [DATA_W-1:0] mem [2**ADDR_W];
  assign rif.mem_rdata = mem[rif.raddr];

  int                vectors     = 0;
  int                miscompares = 0;
  logic [DATA_W-1:0] sb [$];
  int                m_avail     = 0;
  logic [PW-1:0]     wbin        = '0;

  function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Write side: store the word, advance the Gray pointer, expect it back later.
  task automatic push_word(input logic [DATA_W-1:0] v);
    mem[wbin[ADDR_W-1:0]] = v;
    wbin = wbin + 1'b1;
    rif.wptr_gray = gray(wbin);
    sb.push_back(v);
  endtask

  // One clock; in standard mode predict rvalid and score the popped data.
  task automatic cyc();
    logic              exp_v;
    logic [DATA_W-1:0] exp_d;
    exp_v = rst && rif.rinc && (m_avail > 0);
    if (exp_v) m_avail--;
    @(posedge clk);
    #1;
`ifndef FIFO_RD_FWFT_EN
    vectors++;
    if (rif.rvalid !== exp_v) begin
      miscompares++;
      $display("FAIL rvalid_strobe: got %b want %b at %0t", rif.rvalid, exp_v, $time);
    end
    if (exp_v && sb.size() > 0) begin
      exp_d = sb.pop_front();
      vectors++;
      if (rif.rdata !== exp_d) begin
        miscompares++;
        $display("FAIL rdata_order: got %h want %h at %0t", rif.rdata, exp_d, $time);
      end
    end
`endif
  endtask

  task automatic settle();
    rif.rinc = 1'b0;
    repeat (SYNC_STAGES + 1) cyc();
    m_avail = sb.size();
  endtask

  task automatic do_reset();
    rif.rinc      = 1'b0;
    wbin          = '0;
    rif.wptr_gray = '0;
    sb.delete();
    m_avail = 0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rif.rinc      = 1'b0;
    rif.wptr_gray = '0;
    #3;
    rst = 1'b0;
    #1;
    // checked before any clock edge: reset must act asynchronously
    vectors += 8;
    if (rif.rempty !== 1'b1)     begin miscompares++; $display("FAIL rst_rempty: got %b want 1", rif.rempty); end
    if (rif.raempty !== 1'b1)    begin miscompares++; $display("FAIL rst_raempty: got %b want 1", rif.raempty); end
    if (rif.rcount !== '0)       begin miscompares++; $display("FAIL rst_rcount: got %0d want 0", rif.rcount); end
    if (rif.runderflow !== 1'b0) begin miscompares++; $display("FAIL rst_runderflow: got %b want 0", rif.runderflow); end
    if (rif.rvalid !== 1'b0)     begin miscompares++; $display("FAIL rst_rvalid: got %b want 0", rif.rvalid); end
    if (rif.rdata !== '0)        begin miscompares++; $display("FAIL rst_rdata: got %h want 0", rif.rdata); end
    if (rif.raddr !== '0)        begin miscompares++; $display("FAIL rst_raddr: got %0d want 0", rif.raddr); end
    if (rif.rptr_gray !== '0)    begin miscompares++; $display("FAIL rst_rptr_gray: got %h want 0", rif.rptr_gray); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_underflow();
    do_reset();
    rif.rinc = 1'b1;
    cyc();
    rif.rinc = 1'b0;
    vectors += 4;
    if (rif.runderflow !== 1'b1) begin miscompares++; $display("FAIL uf_flag: got %b want 1", rif.runderflow); end
    if (rif.rempty !== 1'b1)     begin miscompares++; $display("FAIL uf_rempty: got %b want 1", rif.rempty); end
    if (rif.raddr !== '0)        begin miscompares++; $display("FAIL uf_raddr: got %0d want 0", rif.raddr); end
    if (rif.rvalid !== 1'b0)     begin miscompares++; $display("FAIL uf_rvalid: got %b want 0", rif.rvalid); end
    repeat (3) cyc();
    vectors++;
    if (rif.runderflow !== 1'b1) begin miscompares++; $display("FAIL uf_sticky: got %b want 1", rif.runderflow); end
  endtask

  task automatic test_sync_latency();
    do_reset();
    for (int i = 0; i < 3; i++) push_word(DATA_W'(8'h11 + i));
    for (int c = 1; c <= SYNC_STAGES + 1; c++) begin
      cyc();
      if (c == SYNC_STAGES) begin
        vectors += 2;
        if (rif.rempty !== 1'b1) begin miscompares++; $display("FAIL sync_early_rempty: got %b want 1", rif.rempty); end
        if (rif.rcount !== '0)   begin miscompares++; $display("FAIL sync_early_rcount: got %0d want 0", rif.rcount); end
      end
    end
    vectors += 3;
    if (rif.rempty !== 1'b0)       begin miscompares++; $display("FAIL sync_rempty: got %b want 0", rif.rempty); end
    if (rif.rcount !== PW'(3))     begin miscompares++; $display("FAIL sync_rcount: got %0d want 3", rif.rcount); end
    if (rif.raempty !== 1'b0)      begin miscompares++; $display("FAIL sync_raempty: got %b want 0", rif.raempty); end
    m_avail = sb.size();
    rif.rinc = 1'b1;
    repeat (3) cyc();
    rif.rinc = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic exp_ae;
    do_reset();
    for (int i = 0; i < 4; i++) push_word(DATA_W'(8'hA0 + i));
    settle();
    vectors += 2;
    if (rif.rcount !== PW'(4)) begin miscompares++; $display("FAIL b2b_rcount_init: got %0d want 4", rif.rcount); end
    if (rif.raempty !== 1'b0)  begin miscompares++; $display("FAIL b2b_raempty_init: got %b want 0", rif.raempty); end
    rif.rinc = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      exp_ae = ((4 - k) <= AEMPTY_TH);
      vectors += 2;
      if (rif.rcount !== PW'(4 - k)) begin miscompares++; $display("FAIL b2b_rcount: got %0d want %0d", rif.rcount, 4 - k); end
      if (rif.raempty !== exp_ae)    begin miscompares++; $display("FAIL b2b_raempty: got %b want %b", rif.raempty, exp_ae); end
    end
    rif.rinc = 1'b0;
    vectors += 2;
    if (rif.rempty !== 1'b1)     begin miscompares++; $display("FAIL b2b_rempty: got %b want 1", rif.rempty); end
    if (rif.runderflow !== 1'b0) begin miscompares++; $display("FAIL b2b_runderflow: got %b want 0", rif.runderflow); end
    cyc();
  endtask

  task automatic test_wrap();
    int            popped;
    logic [PW-1:0] pb;
    do_reset();
    popped = 0;
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 8; i++) push_word(DATA_W'(8'h30 + b * 8 + i));
      settle();
      rif.rinc = 1'b1;
      for (int i = 0; i < 8; i++) begin
        cyc();
        popped++;
        pb = PW'(popped);
        vectors += 2;
        if (rif.raddr !== pb[ADDR_W-1:0]) begin miscompares++; $display("FAIL wrap_raddr: got %0d want %0d", rif.raddr, pb[ADDR_W-1:0]); end
        if (rif.rptr_gray !== gray(pb))   begin miscompares++; $display("FAIL wrap_rptr_gray: got %h want %h", rif.rptr_gray, gray(pb)); end
      end
      rif.rinc = 1'b0;
    end
    cyc();
    vectors++;
    if (rif.rempty !== 1'b1) begin miscompares++; $display("FAIL wrap_rempty: got %b want 1", rif.rempty); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++) push_word(DATA_W'(8'h60 + i));
    settle();
    rif.rinc = 1'b1;
    repeat (3) cyc();
    #2;
    rst = 1'b0;
    rif.rinc = 1'b0;
    #1;
    vectors += 8;
    if (rif.rempty !== 1'b1)     begin miscompares++; $display("FAIL mid_rempty: got %b want 1", rif.rempty); end
    if (rif.raempty !== 1'b1)    begin miscompares++; $display("FAIL mid_raempty: got %b want 1", rif.raempty); end
    if (rif.rcount !== '0)       begin miscompares++; $display("FAIL mid_rcount: got %0d want 0", rif.rcount); end
    if (rif.runderflow !== 1'b0) begin miscompares++; $display("FAIL mid_runderflow: got %b want 0", rif.runderflow); end
    if (rif.rvalid !== 1'b0)     begin miscompares++; $display("FAIL mid_rvalid: got %b want 0", rif.rvalid); end
    if (rif.rdata !== '0)        begin miscompares++; $display("FAIL mid_rdata: got %h want 0", rif.rdata); end
    if (rif.raddr !== '0)        begin miscompares++; $display("FAIL mid_raddr: got %0d want 0", rif.raddr); end
    if (rif.rptr_gray !== '0)    begin miscompares++; $display("FAIL mid_rptr_gray: got %h want 0", rif.rptr_gray); end
    // write domain restarts too; in-flight entries are abandoned
    sb.delete();
    m_avail = 0;
    wbin = '0;
    rif.wptr_gray = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_word(8'hC3);
    settle();
    vectors++;
    if (rif.raddr !== '0) begin miscompares++; $display("FAIL mid_restart_raddr: got %0d want 0", rif.raddr); end
    rif.rinc = 1'b1;
    cyc();
    rif.rinc = 1'b0;
    vectors++;
    if (rif.raddr !== PW'(1)) begin miscompares++; $display("FAIL mid_next_raddr: got %0d want 1", rif.raddr); end
    cyc();
  endtask

`ifdef FIFO_RD_FWFT_EN
  task automatic test_fwft();
    int waited;
    do_reset();
    push_word(8'h5A);
    rif.rinc = 1'b0;
    waited = 0;
    while (rif.rvalid !== 1'b1 && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
    end
    vectors += 4;
    if (waited !== SYNC_STAGES + 2) begin miscompares++; $display("FAIL fwft_latency: got %0d cycles want %0d", waited, SYNC_STAGES + 2); end
    if (rif.rdata !== 8'h5A)        begin miscompares++; $display("FAIL fwft_rdata: got %h want 5a", rif.rdata); end
    if (rif.rempty !== 1'b1)        begin miscompares++; $display("FAIL fwft_rempty_held: got %b want 1", rif.rempty); end
    if (rif.rcount !== '0)          begin miscompares++; $display("FAIL fwft_rcount: got %0d want 0", rif.rcount); end
    rif.rinc = 1'b1;
    @(posedge clk);
    #1;
    rif.rinc = 1'b0;
    vectors += 3;
    if (rif.rvalid !== 1'b0)     begin miscompares++; $display("FAIL fwft_rvalid_pop: got %b want 0", rif.rvalid); end
    if (rif.rempty !== 1'b1)     begin miscompares++; $display("FAIL fwft_rempty_pop: got %b want 1", rif.rempty); end
    if (rif.runderflow !== 1'b0) begin miscompares++; $display("FAIL fwft_runderflow: got %b want 0", rif.runderflow); end
  endtask
`endif

  initial begin
    rif.rinc      = 1'b0;
    rif.wptr_gray = '0;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
    test_reset();
    test_underflow();
    test_sync_latency();
`ifdef FIFO_RD_FWFT_EN
    test_fwft();
`else
    test_back_to_back();
    test_wrap();
    test_reset_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
